// File: rtl/pll_drp_pkg.sv
// Shared types and helpers for the PLL DRP read-modify-write sequencer.
package pll_drp_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_LOCK_WAIT
  } drp_state_e;

  // A mask bit of 1 keeps the old register bit; 0 takes the new data bit.
  function automatic logic [DRP_DATA_W-1:0] drp_merge(
    input logic [DRP_DATA_W-1:0] old,
    input logic [DRP_DATA_W-1:0] data,
    input logic [DRP_DATA_W-1:0] mask
  );
    return (old & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/pll_drp_ctrl_if.sv
// Request handshake, DRP bus and PLL control signals of the sequencer.
interface pll_drp_ctrl_if;
  import pll_drp_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [DRP_ADDR_W-1:0] req_addr;
  logic [DRP_DATA_W-1:0] req_data;
  logic [DRP_DATA_W-1:0] req_mask;
  logic                  done;
  logic                  err;
  logic [DRP_ADDR_W-1:0] drp_daddr;
  logic                  drp_den;
  logic                  drp_dwe;
  logic [DRP_DATA_W-1:0] drp_di;
  logic [DRP_DATA_W-1:0] drp_do;
  logic                  drp_drdy;
  logic                  pll_rst;
  logic                  pll_locked;

  modport master (
    input  req_valid, req_addr, req_data, req_mask, drp_do, drp_drdy, pll_locked,
    output req_ready, done, err, drp_daddr, drp_den, drp_dwe, drp_di, pll_rst
  );

  modport slave (
    output req_valid, req_addr, req_data, req_mask, drp_do, drp_drdy, pll_locked,
    input  req_ready, done, err, drp_daddr, drp_den, drp_dwe, drp_di, pll_rst
  );

endinterface

// File: rtl/pll_drp_ctrl_timer.sv
// Loadable down-counter that stops at zero and flags expiry.
module drp_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o   = cnt_q;
  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pll_drp_ctrl.sv
// PLL DRP read-modify-write sequencer: holds the PLL in reset around the access, then waits for lock.
module pll_drp_ctrl
  import pll_drp_pkg::*;
#(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_BLANK   = 4
) (
  input  logic           clk,
  input  logic           rst,
  pll_drp_ctrl_if.master bus
);

  localparam int MAX_TO = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int TW     = $clog2(MAX_TO) + 1;
  // The timer is loaded on entry to a wait state, one cycle after DEN for DRP
  // waits, so the last cycle in which DRDY is still accepted is DEN + DRDY_TIMEOUT - 1.
  localparam logic [TW-1:0] DRDY_LOAD = TW'(DRDY_TIMEOUT - 2);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] BLANK_THR = TW'(LOCK_TIMEOUT - 1 - LOCK_BLANK);

  drp_state_e            state_q, state_d;
  logic [DRP_ADDR_W-1:0] addr_q, addr_d;
  logic [DRP_DATA_W-1:0] data_q, data_d;
  logic [DRP_DATA_W-1:0] mask_q, mask_d;
  logic [DRP_DATA_W-1:0] di_q, di_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  done_c, err_c;
  logic                  tmr_load, tmr_expired, blank_done;
  logic [TW-1:0]         tmr_val, tmr_cnt;

  drp_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_o    (tmr_cnt),
    .expired_o  (tmr_expired)
  );

  // The shared counter doubles as the lock-wait blanking timer.
  assign blank_done = (tmr_cnt <= BLANK_THR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    di_d    = di_q;
    done_c  = 1'b0;
    err_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          data_d  = bus.req_data;
          mask_d  = bus.req_mask;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus.drp_drdy) begin
          di_d    = drp_merge(bus.drp_do, data_q, mask_q);
          state_d = S_WR;
        end else if (tmr_expired) begin
          done_c  = 1'b1;
          err_c   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus.drp_drdy) begin
          state_d = S_LOCK_WAIT;
        end else if (tmr_expired) begin
          done_c  = 1'b1;
          err_c   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LOCK_WAIT: begin
        if (blank_done && bus.pll_locked) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end else if (tmr_expired) begin
          done_c  = 1'b1;
          err_c   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pll_rst_d = (state_d inside {S_RD, S_RD_WAIT, S_WR, S_WR_WAIT});
    tmr_load  = (state_d != state_q);
    tmr_val   = (state_d == S_LOCK_WAIT) ? LOCK_LOAD : DRDY_LOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      di_q      <= '0;
      pll_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      di_q      <= di_d;
      pll_rst_q <= pll_rst_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.done      = done_c;
  assign bus.err       = err_c;
  assign bus.drp_daddr = addr_q;
  assign bus.drp_den   = (state_q == S_RD) || (state_q == S_WR);
  assign bus.drp_dwe   = (state_q == S_WR);
  assign bus.drp_di    = di_q;
  assign bus.pll_rst   = pll_rst_q;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Directed bench for pll_drp_ctrl: RMW, slow/absent DRDY, lock blanking/timeout, stray DRDY, mid-op reset.
module tb_pll_drp_ctrl;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  pll_drp_ctrl_if bus ();

  pll_drp_ctrl #(
    .DRDY_TIMEOUT (64),
    .LOCK_TIMEOUT (4096),
    .LOCK_BLANK   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  // Starts in an IDLE cycle; ends positioned at the write-DEN cycle.
  task automatic read_phase(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m,
                            input int lat, input logic stray, input logic [15:0] rdval);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_mask  = m;
    #2 chk("req_ready", bus.req_ready, 1);
    nxt();
    bus.req_valid = 1'b0;
    bus.drp_drdy  = stray;
    bus.drp_do    = 16'hDEAD;
    #2 chk("rd_den_dwe", {bus.drp_den, bus.drp_dwe}, 2'b10);
    chk("rd_daddr", bus.drp_daddr, a);
    chk("rd_pll_rst", bus.pll_rst, 1);
    nxt();
    for (int i = 1; i < lat; i++) begin
      bus.drp_drdy = 1'b0;
      #2 chk("rdwait_done_den", {bus.done, bus.drp_den}, 0);
      nxt();
    end
    bus.drp_drdy = 1'b1;
    bus.drp_do   = rdval;
    #2 chk("rdwait_drdy_done", bus.done, 0);
    nxt();
  endtask

  // Starts at the write-DEN cycle; zero-wait write ack; ends at first LOCK_WAIT cycle.
  task automatic write_phase(input logic [15:0] expdi);
    bus.drp_drdy = 1'b0;
    bus.drp_do   = '0;
    #2 chk("wr_den_dwe", {bus.drp_den, bus.drp_dwe}, 2'b11);
    chk("wr_di", bus.drp_di, expdi);
    chk("wr_pll_rst", bus.pll_rst, 1);
    nxt();
    bus.drp_drdy = 1'b1;
    #2 chk("wrwait_den", bus.drp_den, 0);
    chk("wrwait_pll_rst", bus.pll_rst, 1);
    nxt();
  endtask

  // Starts at the first LOCK_WAIT cycle; locked rises lockd cycles in.
  task automatic lock_phase(input int lockd);
    int exp_cycle;
    exp_cycle = (lockd > 4) ? lockd : 4;
    for (int i = 0; i <= exp_cycle; i++) begin
      bus.drp_drdy   = 1'b0;
      bus.pll_locked = (i >= lockd);
      #2 chk("lock_done", bus.done, (i == exp_cycle));
      if (i == 0) chk("lock_pll_rst", bus.pll_rst, 0);
      if (i == exp_cycle) chk("lock_err", bus.err, 0);
      nxt();
    end
    bus.pll_locked = 1'b0;
    #2 chk("post_done_ready", bus.req_ready, 1);
    chk("post_done_done", bus.done, 0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.req_mask   = '0;
    bus.drp_do     = '0;
    bus.drp_drdy   = 1'b0;
    bus.pll_locked = 1'b0;
    nxt();
    nxt();
    #2 chk("rst_ready", bus.req_ready, 1);
    chk("rst_outs", {bus.done, bus.err, bus.drp_den, bus.drp_dwe, bus.pll_rst}, 0);
    chk("rst_daddr", bus.drp_daddr, 0);
    chk("rst_di", bus.drp_di, 0);
    nxt();
    rst = 1'b0;
    nxt();

    // Basic RMW, lock 10 cycles into LOCK_WAIT
    read_phase(7'h08, 16'h1041, 16'hF000, 1, 1'b0, 16'h5FFF);
    write_phase(16'h5041);
    lock_phase(10);
    nxt();

    // Lock blanking: locked held high, done in 5th LOCK_WAIT cycle
    read_phase(7'h4F, 16'h0000, 16'hFFFF, 1, 1'b0, 16'h1234);
    write_phase(16'h1234);
    lock_phase(0);
    nxt();

    // Slow responder: DRDY 63 cycles after read DEN still succeeds
    read_phase(7'h28, 16'hABCD, 16'h0F0F, 63, 1'b0, 16'h00FF);
    write_phase(16'hA0CF);
    lock_phase(4);
    nxt();

    // Read timeout: DRDY 64 cycles after DEN arrives too late
    bus.req_valid = 1'b1;
    bus.req_addr  = 7'h11;
    nxt();
    bus.req_valid = 1'b0;
    #2 chk("rdto_den", bus.drp_den, 1);
    nxt();
    for (int i = 1; i <= 63; i++) begin
      bus.drp_drdy = 1'b0;
      #2 chk("rdto_done", bus.done, (i == 63));
      if (i == 63) chk("rdto_err", bus.err, 1);
      else chk("rdto_no_den", bus.drp_den, 0);
      nxt();
    end
    bus.drp_drdy = 1'b1;
    bus.drp_do   = 16'hFFFF;
    #2 chk("rdto_ready", bus.req_ready, 1);
    chk("rdto_pll_rst", bus.pll_rst, 0);
    chk("rdto_late_den", {bus.drp_den, bus.done}, 0);
    nxt();
    bus.drp_drdy = 1'b0;
    #2 chk("rdto_no_wr", {bus.drp_den, bus.drp_dwe}, 0);
    chk("rdto_di_hold", bus.drp_di, 16'hA0CF);
    chk("rdto_daddr", bus.drp_daddr, 7'h11);
    nxt();

    // Write timeout: write DRDY never comes
    read_phase(7'h12, 16'h00F0, 16'hFF0F, 1, 1'b0, 16'h1111);
    bus.drp_drdy = 1'b0;
    #2 chk("wrto_di", bus.drp_di, 16'h11F1);
    nxt();
    for (int i = 0; i <= 62; i++) begin
      #2 chk("wrto_done", bus.done, (i == 62));
      if (i == 62) chk("wrto_err", bus.err, 1);
      else chk("wrto_pll_rst_hi", bus.pll_rst, 1);
      nxt();
    end
    #2 chk("wrto_pll_rst_lo", bus.pll_rst, 0);
    chk("wrto_ready", bus.req_ready, 1);
    nxt();

    // Stray DRDY in IDLE, then DRDY coincident with read DEN
    bus.drp_drdy = 1'b1;
    bus.drp_do   = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      #2 chk("idle_drdy_ready", bus.req_ready, 1);
      chk("idle_drdy_outs", {bus.drp_den, bus.pll_rst, bus.done}, 0);
      nxt();
    end
    bus.drp_drdy = 1'b0;
    #2 chk("idle_di_hold", bus.drp_di, 16'h11F1);
    read_phase(7'h33, 16'h8001, 16'h7FFE, 3, 1'b1, 16'h0F0F);
    write_phase(16'h8F0F);
    lock_phase(5);
    nxt();

    // Lock timeout: done+err in the 4096th LOCK_WAIT cycle
    read_phase(7'h7F, 16'hFFFF, 16'h0000, 1, 1'b0, 16'h0000);
    write_phase(16'hFFFF);
    bus.drp_drdy = 1'b0;
    for (int i = 0; i <= 4095; i++) begin
      #2 chk("lockto_done", bus.done, (i == 4095));
      if (i == 4095) chk("lockto_err", bus.err, 1);
      nxt();
    end
    #2 chk("lockto_ready", bus.req_ready, 1);
    chk("lockto_pll_rst", bus.pll_rst, 0);
    nxt();

    // Reset asserted in WR_WAIT
    read_phase(7'h05, 16'h0003, 16'hFFFC, 1, 1'b0, 16'h1000);
    bus.drp_drdy = 1'b0;
    #2 chk("mrst_di", bus.drp_di, 16'h1003);
    nxt();
    rst = 1'b1;
    #2 chk("mrst_pll_rst_hi", bus.pll_rst, 1);
    nxt();
    rst = 1'b0;
    #2 chk("mrst_ready", bus.req_ready, 1);
    chk("mrst_outs", {bus.pll_rst, bus.done, bus.err, bus.drp_den}, 0);
    chk("mrst_di_rst", bus.drp_di, 0);
    chk("mrst_daddr_rst", bus.drp_daddr, 0);
    nxt();
    bus.drp_drdy = 1'b1;
    #2 chk("mrst_late_drdy", {bus.req_ready, bus.drp_den, bus.pll_rst, bus.done}, 4'b1000);
    nxt();
    bus.drp_drdy = 1'b0;
    #2 chk("mrst_still_idle", {bus.req_ready, bus.drp_den}, 2'b10);
    nxt();
    read_phase(7'h06, 16'h00A5, 16'hFF00, 1, 1'b0, 16'h5A5A);
    write_phase(16'h5AA5);
    lock_phase(6);
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
